// File: rtl/fpgaudio_pkg.sv
// ----------------------------------------------------------------------------
// fpgaudio_pkg
// Shared definitions for the FPGAudio melody recorder (mode 2) and the
// playback decoder (mode 1).
//   estado_t          : recorder FSM state encoding (also exposed on db_estado)
//   NOTA_W            : width of a note code
//   NOTA_SILENCIO     : note code used for silence / rests
//   onehot_para_nota  : 12-bit key vector -> note code (lowest pressed index
//                       wins, key i -> code i+1, no key -> silence)
// ----------------------------------------------------------------------------
package fpgaudio_pkg;

   localparam int NOTA_W = 4;
   localparam logic [NOTA_W-1:0] NOTA_SILENCIO = '0;

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
      ESPERA_NOTA  = 4'd2,
      MEDINDO      = 4'd3,
      GRAVA        = 4'd4,
      PROXIMO      = 4'd5,
      FIM_GRAVACAO = 4'd6,
      GRAVA_PAUSA  = 4'd7
   } estado_t;

   // Scans from the top so the lowest set index is the last one assigned.
   function automatic logic [NOTA_W-1:0] onehot_para_nota(input logic [11:0] teclas);
      logic [NOTA_W-1:0] nota;
      nota = NOTA_SILENCIO;
      for (int i = 11; i >= 0; i--) begin
         if (teclas[i]) nota = NOTA_W'(i + 1);
      end
      return nota;
   endfunction

endpackage

// File: rtl/modo2_gravador_melodia_contador_duracao.sv
// ----------------------------------------------------------------------------
// contador_duracao
// Beat-unit duration counter: a TICK_DIV-cycle prescaler feeding a saturating
// DUR_W-bit counter.
//   clock, reset : clock (rising edge), asynchronous active-low reset
//   zera         : restart a measurement: prescaler <- 0, duracao <- 1
//   conta        : advance the prescaler by one cycle
//   duracao      : measured duration in beat units, saturates at 2**DUR_W-1
//   tick         : one-cycle pulse when the prescaler wraps
// zera has priority over conta. Reset leaves duracao at 0.
// ----------------------------------------------------------------------------
module contador_duracao #(
   parameter int DUR_W    = 4,
   parameter int TICK_DIV = 12_500_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             zera,
   input  logic             conta,
   output logic [DUR_W-1:0] duracao,
   output logic             tick
);

   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] DUR_MAX = '1;

   logic [PRE_W-1:0] prescaler;

   assign tick = conta && !zera && (prescaler == PRE_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         duracao   <= '0;
      end else if (zera) begin
         prescaler <= '0;
         duracao   <= DUR_W'(1);
      end else if (conta) begin
         if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            if (duracao != DUR_MAX) duracao <= duracao + DUR_W'(1);
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/modo2_gravador_melodia.sv
// ----------------------------------------------------------------------------
// modo2_gravador_melodia
// Recording-mode controller/datapath: samples the piano keys, times each key
// hold in beat units and writes one {nota, duracao} word per note into the
// melody RAM read by mode-1 playback.
// Optional build macro: REST_RECORD_EN -- when defined, silences between notes
// (after the first word) are timed and stored as {NOTA_SILENCIO, duracao}.
// Ports:
//   clock, reset     : clock (rising edge), asynchronous active-low reset
//   iniciar          : level, starts/restarts a recording (INICIAL/FIM only)
//   finalizar        : level, ends the recording
//   botoes[11:0]     : piano keys, active-high, lowest index wins
//   mem_addr         : RAM write address
//   mem_dado         : RAM write word {nota, duracao}
//   mem_we           : one-cycle write strobe (RAM writes on the same edge)
//   num_notas        : words written in the current/last recording
//   toca, nota_atual : key being measured and its code (buzzer drive)
//   gravando         : recording in progress
//   cheio            : memory filled during this recording
//   fim              : recording finished
//   db_estado        : current FSM state
// Moore machine: every output is decoded from registered state/datapath, so
// an asynchronous reset drops an in-flight mem_we immediately.
// ----------------------------------------------------------------------------
module modo2_gravador_melodia
   import fpgaudio_pkg::*;
#(
   parameter int NOTE_W   = 4,
   parameter int DUR_W    = 4,
   parameter int ADDR_W   = 5,
   parameter int TICK_DIV = 12_500_000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    iniciar,
   input  logic                    finalizar,
   input  logic [11:0]             botoes,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [NOTE_W+DUR_W-1:0] mem_dado,
   output logic                    mem_we,
   output logic [ADDR_W:0]         num_notas,
   output logic                    toca,
   output logic [NOTE_W-1:0]       nota_atual,
   output logic                    gravando,
   output logic                    cheio,
   output logic                    fim,
   output logic [3:0]              db_estado
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   estado_t estado, estado_prox;

   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   contagem;
   logic [NOTE_W-1:0] codigo;
   logic [NOTE_W-1:0] nota_lida;
   logic [DUR_W-1:0]  duracao;
   logic              fin_pendente;
   logic              cheio_r;
   logic              zera;
   logic              conta;
   logic              tick_unused;

   assign nota_lida = NOTE_W'(onehot_para_nota(botoes));

`ifdef REST_RECORD_EN
   // A rest is worth storing only once at least one full beat has elapsed.
   logic pausa_valida;
   assign pausa_valida = (contagem != '0) && (duracao >= DUR_W'(2));
`endif

   contador_duracao #(
      .DUR_W    (DUR_W),
      .TICK_DIV (TICK_DIV)
   ) u_contador (
      .clock   (clock),
      .reset   (reset),
      .zera    (zera),
      .conta   (conta),
      .duracao (duracao),
      .tick    (tick_unused)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) estado <= INICIAL;
      else        estado <= estado_prox;
   end

   // Next state and counter control
   always_comb begin
      estado_prox = estado;
      zera        = 1'b0;
      conta       = 1'b0;
      case (estado)
         INICIAL:     if (iniciar) estado_prox = PREPARA;
         PREPARA:     estado_prox = ESPERA_NOTA;
         ESPERA_NOTA: begin
            // finalizar wins over a key pressed in the same cycle
            if (finalizar) begin
               estado_prox = FIM_GRAVACAO;
            end else if (botoes != 12'd0) begin
`ifdef REST_RECORD_EN
               if (pausa_valida) begin
                  estado_prox = GRAVA_PAUSA;
               end else begin
                  zera        = 1'b1;
                  estado_prox = MEDINDO;
               end
`else
               zera        = 1'b1;
               estado_prox = MEDINDO;
`endif
            end else begin
`ifdef REST_RECORD_EN
               conta = (contagem != '0);
`endif
            end
         end
         MEDINDO: begin
            conta = 1'b1;
            if ((botoes == 12'd0) || (nota_lida != codigo) || finalizar)
               estado_prox = GRAVA;
         end
         GRAVA:       estado_prox = PROXIMO;
         PROXIMO: begin
`ifdef REST_RECORD_EN
            // start timing the silence that follows this note
            zera = 1'b1;
`endif
            if ((addr == ADDR_MAX) || fin_pendente) estado_prox = FIM_GRAVACAO;
            else                                    estado_prox = ESPERA_NOTA;
         end
         FIM_GRAVACAO: if (iniciar) estado_prox = PREPARA;
         GRAVA_PAUSA: begin
`ifdef REST_RECORD_EN
            // the key that ended the rest is measured from here on
            zera = 1'b1;
            if (addr == ADDR_MAX) estado_prox = FIM_GRAVACAO;
            else                  estado_prox = MEDINDO;
`else
            estado_prox = INICIAL;
`endif
         end
         default:     estado_prox = INICIAL;
      endcase
   end

   // Address, note count, latched code and flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr         <= '0;
         contagem     <= '0;
         codigo       <= '0;
         fin_pendente <= 1'b0;
         cheio_r      <= 1'b0;
      end else begin
         case (estado)
            PREPARA: begin
               addr         <= '0;
               contagem     <= '0;
               fin_pendente <= 1'b0;
               cheio_r      <= 1'b0;
            end
            ESPERA_NOTA: begin
               if (!finalizar && (botoes != 12'd0)) codigo <= nota_lida;
            end
            MEDINDO: begin
               if (finalizar) fin_pendente <= 1'b1;
            end
            GRAVA: contagem <= contagem + (ADDR_W+1)'(1);
            PROXIMO: begin
               // addr never wraps: the last word ends the recording
               if (addr == ADDR_MAX)   cheio_r <= 1'b1;
               else if (!fin_pendente) addr    <= addr + ADDR_W'(1);
            end
`ifdef REST_RECORD_EN
            GRAVA_PAUSA: begin
               contagem <= contagem + (ADDR_W+1)'(1);
               if (addr == ADDR_MAX) cheio_r <= 1'b1;
               else                  addr    <= addr + ADDR_W'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   // Outputs
`ifdef REST_RECORD_EN
   assign mem_we   = (estado == GRAVA) || (estado == GRAVA_PAUSA);
   assign mem_dado = (estado == GRAVA_PAUSA) ? {NOTE_W'(NOTA_SILENCIO), duracao}
                                             : {codigo, duracao};
   assign gravando = (estado == ESPERA_NOTA) || (estado == MEDINDO) ||
                     (estado == GRAVA) || (estado == PROXIMO) ||
                     (estado == GRAVA_PAUSA);
`else
   assign mem_we   = (estado == GRAVA);
   assign mem_dado = {codigo, duracao};
   assign gravando = (estado == ESPERA_NOTA) || (estado == MEDINDO) ||
                     (estado == GRAVA) || (estado == PROXIMO);
`endif
   assign mem_addr   = addr;
   assign num_notas  = contagem;
   assign toca       = (estado == MEDINDO);
   assign nota_atual = toca ? codigo : '0;
   assign cheio      = cheio_r;
   assign fim        = (estado == FIM_GRAVACAO);
   assign db_estado  = estado;

endmodule
